if_id_skid_reg: RTL and testbench
=================================

# if_id_skid_reg

Two-entry skid-buffered pipeline register between the instruction-fetch stage and the decode stage of the pipelined RISC-V core. It carries a fetched {PC, instruction} word with a valid/ready handshake, so a decode stall never creates a combinational ready path back into fetch. It sustains one word per cycle, adds one cycle of latency, and supports a synchronous flush for branch/jump redirects.

## Interface
- DATA_W, 64, payload width; fetch packs {pc[31:0], instr[31:0]}.

- clk  input  1  rising-edge clock; all state changes on this edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all held words (branch/jump redirect from EX).
- in_valid  input  1  fetch presents a word.
- in_ready  output  1  buffer can accept a word; driven directly from a register.
- in_data  input  DATA_W  word from fetch.
- out_valid  output  1  decode-side word valid.
- out_ready  input  1  decode accepts the word (low = stall).
- out_data  output  DATA_W  word to decode; driven directly from a register.
- count  output  2  number of held words, 0..2.

## Operation
- Storage: main register (drives out_data/out_valid) and skid register (skid_data, skid_valid).
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State machine, encoded by occupancy:
  - EMPTY (count 0): in_fire -> BUSY, main <= in_data.
  - BUSY (count 1):
    - in_fire & out_fire -> BUSY, main <= in_data.
    - in_fire only -> FULL, skid <= in_data.
    - out_fire only -> EMPTY.
    - neither -> hold.
  - FULL (count 2): in_ready = 0. out_fire -> BUSY, main <= skid. No out_fire -> hold both registers.
- in_ready = !skid_valid, registered. It is never a function of out_ready in the same cycle.
- Ordering is strictly FIFO: the skid word always leaves after the main word.
- Event priority: rst > flush > handshakes.
- flush: next state EMPTY, out_valid = 0, skid_valid = 0, in_ready = 1.
  - Any in_fire or out_fire in the flush cycle is discarded.
  - Fetch has already been redirected, so the words it sent are dead.
- Data registers keep their old contents when their valid bit is 0. Data loads only on the transitions listed above.

## Timing
- Reset values: out_valid = 0, out_data = 0, in_ready = 1, count = 0, skid_valid = 0, skid_data = 0. Handshakes in a reset cycle are ignored.
- Latency: in_fire at edge N (EMPTY state) -> out_valid = 1 with that word after edge N, visible in cycle N+1.
- Throughput: one word per cycle while out_ready stays high. No bubbles in steady state.
- Stall absorption: out_ready falls while in_fire -> the word goes to skid, in_ready = 0 in the next cycle. At most one extra word is taken after the stall begins.
- Stall release: the first out_fire in FULL moves skid to main, and in_ready = 1 in the following cycle.
- out_data and out_valid stay stable while out_valid & !out_ready (verification assertion).
- in_ready is low only in FULL. count changes only on a clock edge.
- Simultaneous in_fire & out_fire in BUSY: count stays 1, and out_data becomes the new word on the next edge.
- flush asserted while FULL and in_valid = 1: next cycle count = 0, out_valid = 0, and the in word is lost.
- rst asserted mid-stream: next cycle returns the reset values regardless of the other inputs.

## Test plan
- Reset, then streaming: out_ready = 1, send words 0x1000_0000_0000_0013 .. +4 on consecutive cycles -> each appears on out_data exactly one cycle later, in order, count = 1 throughout, in_ready = 1 always.
- Stall: BUSY holding word A, drop out_ready while sending B -> count = 2, in_ready = 0, out_data = A held. Raise out_ready -> A, then B on consecutive cycles, in_ready = 1 after the A transfer.
- Backpressure hold: FULL with out_ready = 0 for 10 cycles while in_valid = 1 with new data C -> C never accepted, and A and B are unchanged.
- Flush while FULL with in_valid = 1 and out_ready = 1 -> next cycle out_valid = 0, count = 0, in_ready = 1. A word sent on the next cycle is the only one output afterwards.
- Synchronous reset mid-operation (count = 2) with in_valid = 1 -> next cycle out_valid = 0, out_data = 0, count = 0, in_ready = 1. Dropping rst at the clock edge produces no spurious output.
- Random valid/ready stimulus for 10k cycles against a reference FIFO model -> no loss, duplication or reordering. Check the stability assertion and count ≤ 2.

Source files
------------

// File: rtl/if_id_skid_reg.sv
`default_nettype none
// ============================================================================
// if_id_skid_reg : two-entry skid-buffered IF->ID pipeline register
// Rev 1.0 : initial release
// ============================================================================
module if_id_skid_reg #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DATA_W-1:0]  r_main_data;
  logic [DATA_W-1:0]  r_skid_data;
  logic               r_out_valid;
  logic               r_in_ready;

  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_load_main_in;
  logic               w_load_main_skid;
  logic               w_load_skid;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      // Words moving in a flush cycle belong to the squashed path.
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt    = S_BUSY;
            w_load_main_in = 1'b1;
          end
        end
        S_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main_in = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = S_FULL;
            w_load_skid = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_state_nxt      = S_BUSY;
            w_load_main_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  // Handshake flags are registered from the next state so in_ready never
  // depends combinationally on out_ready; in_ready is the skid-valid complement.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_main_data <= '0;
      r_skid_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != S_EMPTY);
      r_in_ready  <= (w_state_nxt != S_FULL);
      if (w_load_main_in) begin
        r_main_data <= in_data;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_data <= in_data;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main_data;
  assign count     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_if_id_skid_reg.sv
`default_nettype none
// ============================================================================
// tb_if_id_skid_reg : self-checking bench, FIFO-queue reference model
// Rev 1.0 : initial release
// ============================================================================
module tb_if_id_skid_reg;

  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        count;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] mq[$];

  always #5 clk = ~clk;

  if_id_skid_reg #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  // Advance one clock and apply the same edge to the two-deep FIFO model.
  task automatic tick();
    bit pop;
    bit push;
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
    end else begin
      pop  = (mq.size() > 0) && out_ready;
      push = in_valid && (mq.size() < 2);
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(in_data);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_data = 64'hDEAD_BEEF_CAFE_F00D;
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_release_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] base;
    base = 64'h1000_0000_0000_0013;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = base + 64'(i);
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== base + 64'(i))
        begin bad++; $display("FAIL stream_data[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, base + 64'(i)); end
      total++; if (count !== 2'd1 || in_ready !== 1'b1)
        begin bad++; $display("FAIL stream_count[%0d] got=%0d/%b exp=1/1", i, count, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0 || count !== 2'd0)
      begin bad++; $display("FAIL stream_drain got=%b/%0d exp=0/0", out_valid, count); end
  endtask

  task automatic fill_full(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    out_ready = 1'b0; flush = 1'b0;
    in_valid = 1'b1; in_data = a; tick();
    in_valid = 1'b1; in_data = b; tick();
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    fill_full(64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0002);
    total++; if (count !== 2'd2 || in_ready !== 1'b0)
      begin bad++; $display("FAIL stall_full got=%0d/%b exp=2/0", count, in_ready); end
    total++; if (out_valid !== 1'b1 || out_data !== 64'hAAAA_0000_0000_0001)
      begin bad++; $display("FAIL stall_hold_a got=%b/%h exp=1/aaaa000000000001", out_valid, out_data); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hCCCC_0000_0000_0003;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (count !== 2'd2 || in_ready !== 1'b0 || out_data !== 64'hAAAA_0000_0000_0001)
        begin bad++; $display("FAIL bp_hold[%0d] got=%0d/%b/%h exp=2/0/aaaa000000000001", i, count, in_ready, out_data); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 64'hBBBB_0000_0000_0002 || in_ready !== 1'b1 || count !== 2'd1)
      begin bad++; $display("FAIL release_b got=%b/%h/%b/%0d exp=1/bbbb000000000002/1/1", out_valid, out_data, in_ready, count); end
    tick();
    total++; if (out_valid !== 1'b0 || count !== 2'd0)
      begin bad++; $display("FAIL release_empty got=%b/%0d exp=0/0 (C must not appear)", out_valid, count); end
  endtask

  task automatic test_flush();
    fill_full(64'h1111, 64'h2222);
    flush = 1'b1; in_valid = 1'b1; in_data = 64'h3333; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL flush_state got=%b/%0d/%b exp=0/0/1", out_valid, count, in_ready); end
    in_valid = 1'b1; in_data = 64'h4444;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 64'h4444)
      begin bad++; $display("FAIL flush_next got=%b/%h exp=1/4444", out_valid, out_data); end
    tick();
    total++; if (out_valid !== 1'b0)
      begin bad++; $display("FAIL flush_only_one got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    fill_full(64'h5555, 64'h6666);
    rst = 1'b1; in_valid = 1'b1; in_data = 64'h7777; out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || out_data !== '0 || count !== 2'd0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL rst_mid got=%b/%h/%0d/%b exp=0/0/0/1", out_valid, out_data, count, in_ready); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0 || count !== 2'd0)
      begin bad++; $display("FAIL rst_mid_release got=%b/%0d exp=0/0", out_valid, count); end
  endtask

  task automatic test_random();
    logic              stalled;
    logic [DATA_W-1:0] held;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      in_data   = {$urandom, $urandom};
      stalled   = out_valid && !out_ready && !flush;
      held      = out_data;
      tick();
      total++; if (count !== 2'(mq.size()) || count > 2'd2)
        begin bad++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", i, count, mq.size()); end
      total++; if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2))
        begin bad++; $display("FAIL rand_flags[%0d] got=%b/%b exp=%b/%b", i, out_valid, in_ready, mq.size() > 0, mq.size() < 2); end
      if (mq.size() > 0) begin
        total++; if (out_data !== mq[0])
          begin bad++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, out_data, mq[0]); end
      end
      if (stalled) begin
        total++; if (out_valid !== 1'b1 || out_data !== held)
          begin bad++; $display("FAIL rand_stable[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, held); end
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
